// File: rtl/alu_sequencer.sv
// Sequences the 8-bit ALU through B-load, execute and flag-capture cycles for a
// single request; opcode 6 runs an 8x8 shift-and-add multiply on the ALU adder.
module alu_sequencer #(
  parameter int unsigned MUL_ENABLE = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic [2:0] i_op,
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic       o_done,
  output logic [7:0] o_result,
  output logic       o_negative,
  output logic       o_zero,
  output logic       o_error,
  output logic [7:0] o_alu_a,
  output logic [7:0] o_alu_b,
  output logic       o_alu_bWr,
  output logic       o_alu_oe,
  output logic       o_alu_subShiftDir,
  output logic [1:0] o_alu_aluOp,
  input  logic [7:0] i_alu_y,
  input  logic       i_alu_negative,
  input  logic       i_alu_zero
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOADB = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_ITER  = 3'd3;
  localparam logic [2:0] S_FLAGS = 3'd4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4;
  localparam logic [2:0] OP_SHR = 3'd5;
  localparam logic [2:0] OP_MUL = 3'd6;

  logic [2:0] state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] acc_q, acc_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] result_q, result_d;
  logic       neg_q, neg_d;
  logic       zero_q, zero_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic       req_legal;
  logic       is_mul;
  logic [7:0] acc_shl;

  assign req_legal = (i_op != 3'd7) && !((i_op == OP_MUL) && (MUL_ENABLE == 0));
  assign is_mul    = (op_q == OP_MUL);
  assign acc_shl   = {acc_q[6:0], 1'b0};

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          if (req_legal) begin
            op_d    = i_op;
            a_d     = i_a;
            b_d     = i_b;
            state_d = S_LOADB;
          end else begin
            // Illegal opcode completes immediately without touching the ALU.
            done_d   = 1'b1;
            err_d    = 1'b1;
            result_d = 8'h00;
            neg_d    = 1'b0;
            zero_d   = 1'b0;
          end
        end
      end
      S_LOADB: begin
        if (is_mul) begin
          cnt_d   = 3'd7;
          acc_d   = 8'h00;
          state_d = S_ITER;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        acc_d   = i_alu_y;
        state_d = S_FLAGS;
      end
      S_ITER: begin
        acc_d = b_q[cnt_q] ? i_alu_y : acc_shl;
        if (cnt_q == 3'd0) state_d = S_FLAGS;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_FLAGS: begin
        result_d = acc_q;
        // The ALU flag register only saw the last partial sum for MUL, so derive flags here.
        if (is_mul) begin
          neg_d  = acc_q[7];
          zero_d = (acc_q == 8'h00);
        end else begin
          neg_d  = i_alu_negative;
          zero_d = i_alu_zero;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_alu_a           = 8'h00;
    o_alu_b           = 8'h00;
    o_alu_bWr         = 1'b0;
    o_alu_oe          = 1'b0;
    o_alu_subShiftDir = 1'b0;
    o_alu_aluOp       = 2'b00;
    case (state_q)
      S_LOADB: begin
        o_alu_bWr = 1'b1;
        o_alu_b   = is_mul ? a_q : b_q;
      end
      S_EXEC: begin
        o_alu_oe = 1'b1;
        o_alu_a  = a_q;
        case (op_q)
          OP_ADD: begin o_alu_aluOp = 2'b00; o_alu_subShiftDir = 1'b0; end
          OP_SUB: begin o_alu_aluOp = 2'b00; o_alu_subShiftDir = 1'b1; end
          OP_AND: begin o_alu_aluOp = 2'b01; o_alu_subShiftDir = 1'b0; end
          OP_XOR: begin o_alu_aluOp = 2'b10; o_alu_subShiftDir = 1'b0; end
          OP_SHL: begin o_alu_aluOp = 2'b11; o_alu_subShiftDir = 1'b1; end
          OP_SHR: begin o_alu_aluOp = 2'b11; o_alu_subShiftDir = 1'b0; end
          default: begin o_alu_aluOp = 2'b00; o_alu_subShiftDir = 1'b0; end
        endcase
      end
      S_ITER: begin
        if (b_q[cnt_q]) begin
          o_alu_oe = 1'b1;
          o_alu_a  = acc_shl;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      op_q     <= 3'd0;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      acc_q    <= 8'h00;
      cnt_q    <= 3'd0;
      result_q <= 8'h00;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign o_ready    = (state_q == S_IDLE);
  assign o_done     = done_q;
  assign o_error    = err_q;
  assign o_result   = result_q;
  assign o_negative = neg_q;
  assign o_zero     = zero_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU model on its control ports.
module tb_alu_sequencer;

  logic       clk;
  logic       i_reset;
  logic       i_valid;
  logic [2:0] i_op;
  logic [7:0] i_a;
  logic [7:0] i_b;

  logic       o_ready, o_done, o_negative, o_zero, o_error;
  logic [7:0] o_result, o_alu_a, o_alu_b;
  logic       o_alu_bWr, o_alu_oe, o_alu_subShiftDir;
  logic [1:0] o_alu_aluOp;
  logic [7:0] alu_y;
  logic       alu_neg, alu_zero;

  logic       n_ready, n_done, n_negative, n_zero, n_error;
  logic [7:0] n_result, n_alu_a, n_alu_b;
  logic       n_alu_bWr, n_alu_oe, n_alu_subShiftDir;
  logic [1:0] n_alu_aluOp;

  int total = 0;
  int bad   = 0;

  alu_sequencer #(.MUL_ENABLE(1)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_a(i_a), .i_b(i_b), .o_done(o_done), .o_result(o_result),
    .o_negative(o_negative), .o_zero(o_zero), .o_error(o_error),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_bWr(o_alu_bWr), .o_alu_oe(o_alu_oe),
    .o_alu_subShiftDir(o_alu_subShiftDir), .o_alu_aluOp(o_alu_aluOp),
    .i_alu_y(alu_y), .i_alu_negative(alu_neg), .i_alu_zero(alu_zero)
  );

  alu_sequencer #(.MUL_ENABLE(0)) dut_nomul (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(n_ready),
    .i_op(i_op), .i_a(i_a), .i_b(i_b), .o_done(n_done), .o_result(n_result),
    .o_negative(n_negative), .o_zero(n_zero), .o_error(n_error),
    .o_alu_a(n_alu_a), .o_alu_b(n_alu_b), .o_alu_bWr(n_alu_bWr), .o_alu_oe(n_alu_oe),
    .o_alu_subShiftDir(n_alu_subShiftDir), .o_alu_aluOp(n_alu_aluOp),
    .i_alu_y(8'h00), .i_alu_negative(1'b0), .i_alu_zero(1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: B register and flag register are clocked; y only meaningful while oe.
  logic [7:0] breg = 8'h00;
  logic [7:0] y_raw;
  always_comb begin
    y_raw = 8'h00;
    case (o_alu_aluOp)
      2'b00: y_raw = o_alu_subShiftDir ? (o_alu_a - breg) : (o_alu_a + breg);
      2'b01: y_raw = o_alu_a & breg;
      2'b10: y_raw = o_alu_a ^ breg;
      default: y_raw = o_alu_subShiftDir ? (o_alu_a << breg[2:0]) : (o_alu_a >> breg[2:0]);
    endcase
  end
  assign alu_y = o_alu_oe ? y_raw : 8'hA5;
  initial begin alu_neg = 1'b0; alu_zero = 1'b0; end
  always @(posedge clk) begin
    if (o_alu_bWr) breg <= o_alu_b;
    if (o_alu_oe) begin
      alu_neg  <= y_raw[7];
      alu_zero <= (y_raw == 8'h00);
    end
  end

  // Drives one request from a negedge sample point and waits for o_done.
  task automatic send_wait(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           output int lat, output int nbwr, output int noe, output logic err);
    i_valid = 1'b1; i_op = op; i_a = a; i_b = b;
    @(posedge clk); #1;
    i_valid = 1'b0; i_op = 3'd0; i_a = 8'hEE; i_b = 8'hEE;
    lat = 0; nbwr = 0; noe = 0; err = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (o_alu_bWr) nbwr++;
      if (o_alu_oe)  noe++;
      if (o_done) begin lat = c; err = o_error; break; end
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_valid = 1'b0; i_op = 3'd0; i_a = 8'h00; i_b = 8'h00;
    repeat (2) @(negedge clk);
    total++;
    if ({o_ready, o_done, o_error, o_negative, o_zero} !== 5'b10000) begin
      bad++; $display("FAIL reset_ctrl got=%b want=10000", {o_ready, o_done, o_error, o_negative, o_zero});
    end
    total++;
    if ({o_result, o_alu_a, o_alu_b, o_alu_bWr, o_alu_oe, o_alu_subShiftDir, o_alu_aluOp} !== 29'd0) begin
      bad++; $display("FAIL reset_data result=%h alu_a=%h alu_b=%h", o_result, o_alu_a, o_alu_b);
    end
    i_reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    int lat, nb, no; logic err;
    send_wait(3'd0, 8'h7F, 8'h01, lat, nb, no, err);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL add_latency got=%0d want=4", lat); end
    total++;
    if ({o_result, o_negative, o_zero, err} !== {8'h80, 3'b100}) begin
      bad++; $display("FAIL add_result got=%h n=%b z=%b e=%b want=80 n=1 z=0 e=0", o_result, o_negative, o_zero, err);
    end
    total++;
    if (nb !== 1 || no !== 1) begin bad++; $display("FAIL add_pulses bwr=%0d oe=%0d want=1/1", nb, no); end
    @(negedge clk);
    total++;
    if (o_done !== 1'b0 || o_result !== 8'h80) begin
      bad++; $display("FAIL done_pulse done=%b result=%h want=0/80", o_done, o_result);
    end
  endtask

  task automatic test_illegal();
    int lat, nb, no; logic err;
    send_wait(3'd7, 8'h12, 8'h34, lat, nb, no, err);
    total++;
    if (lat !== 1 || err !== 1'b1) begin bad++; $display("FAIL illegal_timing lat=%0d err=%b want=1/1", lat, err); end
    total++;
    if ({o_result, o_negative, o_zero, nb[3:0], no[3:0]} !== 18'd0) begin
      bad++; $display("FAIL illegal_out result=%h n=%b z=%b bwr=%0d oe=%0d want all 0", o_result, o_negative, o_zero, nb, no);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, nb, no; logic err;
    send_wait(3'd1, 8'h05, 8'h05, lat, nb, no, err);
    total++;
    if (lat !== 4 || o_result !== 8'h00 || o_zero !== 1'b1 || o_negative !== 1'b0) begin
      bad++; $display("FAIL sub_eq lat=%0d result=%h z=%b n=%b want=4 00 1 0", lat, o_result, o_zero, o_negative);
    end
    send_wait(3'd4, 8'h81, 8'h0B, lat, nb, no, err);
    total++;
    if (lat !== 4 || o_result !== 8'h08 || o_zero !== 1'b0) begin
      bad++; $display("FAIL shl_b2b lat=%0d result=%h z=%b want=4 08 0", lat, o_result, o_zero);
    end
    send_wait(3'd5, 8'h80, 8'h07, lat, nb, no, err);
    total++;
    if (lat !== 4 || o_result !== 8'h01) begin
      bad++; $display("FAIL shr_b2b lat=%0d result=%h want=4 01", lat, o_result);
    end
    send_wait(3'd1, 8'h03, 8'h05, lat, nb, no, err);
    total++;
    if (lat !== 4 || o_result !== 8'hFE || o_negative !== 1'b1) begin
      bad++; $display("FAIL sub_wrap lat=%0d result=%h n=%b want=4 FE 1", lat, o_result, o_negative);
    end
    send_wait(3'd2, 8'hF0, 8'h3C, lat, nb, no, err);
    total++;
    if (o_result !== 8'h30) begin bad++; $display("FAIL and_op result=%h want=30", o_result); end
    send_wait(3'd3, 8'hF0, 8'h3C, lat, nb, no, err);
    total++;
    if (o_result !== 8'hCC || o_negative !== 1'b1) begin
      bad++; $display("FAIL xor_op result=%h n=%b want=CC 1", o_result, o_negative);
    end
    @(negedge clk);
  endtask

  task automatic test_mul();
    int lat, nb, no; logic err;
    send_wait(3'd6, 8'h0D, 8'h0B, lat, nb, no, err);
    total++;
    if (lat !== 11) begin bad++; $display("FAIL mul_latency got=%0d want=11", lat); end
    total++;
    if (o_result !== 8'h8F || o_negative !== 1'b1 || o_zero !== 1'b0 || no !== 3 || nb !== 1) begin
      bad++; $display("FAIL mul_0d_0b result=%h n=%b z=%b oe=%0d bwr=%0d want=8F 1 0 3 1", o_result, o_negative, o_zero, no, nb);
    end
    @(negedge clk);
    send_wait(3'd6, 8'h10, 8'h10, lat, nb, no, err);
    total++;
    if (lat !== 11 || o_result !== 8'h00 || o_zero !== 1'b1 || o_negative !== 1'b0 || no !== 1) begin
      bad++; $display("FAIL mul_10_10 lat=%0d result=%h z=%b n=%b oe=%0d want=11 00 1 0 1", lat, o_result, o_zero, o_negative, no);
    end
    @(negedge clk);
  endtask

  task automatic test_nomul();
    int lat_n, lat_m, nb_n, no_n;
    logic err_n;
    logic [7:0] res_n;
    lat_n = 0; lat_m = 0; nb_n = 0; no_n = 0; err_n = 1'b0; res_n = 8'hFF;
    i_valid = 1'b1; i_op = 3'd6; i_a = 8'h06; i_b = 8'h05;
    @(posedge clk); #1;
    i_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (n_alu_bWr) nb_n++;
      if (n_alu_oe)  no_n++;
      if (n_done && lat_n == 0) begin lat_n = c; err_n = n_error; res_n = n_result; end
      if (o_done && lat_m == 0) lat_m = c;
    end
    total++;
    if (lat_n !== 1 || err_n !== 1'b1 || res_n !== 8'h00 || nb_n !== 0 || no_n !== 0) begin
      bad++; $display("FAIL op6_disabled lat=%0d err=%b result=%h bwr=%0d oe=%0d want=1 1 00 0 0", lat_n, err_n, res_n, nb_n, no_n);
    end
    total++;
    if (lat_m !== 11 || o_result !== 8'h1E) begin
      bad++; $display("FAIL op6_enabled lat=%0d result=%h want=11 1E", lat_m, o_result);
    end
  endtask

  task automatic test_reset_mid();
    int lat, nb, no, ndone; logic err;
    i_valid = 1'b1; i_op = 3'd6; i_a = 8'h0D; i_b = 8'h0B;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 i_reset = 1'b1;
    #1;
    total++;
    if ({o_ready, o_done, o_error, o_negative, o_zero, o_result} !== {5'b10000, 8'h00} ||
        {o_alu_a, o_alu_b, o_alu_bWr, o_alu_oe, o_alu_subShiftDir, o_alu_aluOp} !== 21'd0) begin
      bad++; $display("FAIL async_reset ready=%b result=%h alu_a=%h bwr=%b oe=%b", o_ready, o_result, o_alu_a, o_alu_bWr, o_alu_oe);
    end
    @(negedge clk);
    i_reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (o_done) ndone++;
    end
    total++;
    if (ndone !== 0) begin bad++; $display("FAIL aborted_done got=%0d want=0", ndone); end
    send_wait(3'd0, 8'h02, 8'h03, lat, nb, no, err);
    total++;
    if (lat !== 4 || o_result !== 8'h05) begin
      bad++; $display("FAIL add_after_reset lat=%0d result=%h want=4 05", lat, o_result);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int lat, ndone;
    lat = 0; ndone = 0;
    i_valid = 1'b1; i_op = 3'd0; i_a = 8'h10; i_b = 8'h20;
    @(posedge clk); #1;
    for (int c = 1; c <= 20; c++) begin
      i_op = 3'(c % 6); i_a = 8'(c * 37); i_b = 8'(c * 11);
      @(negedge clk);
      if (o_done) begin lat = c; i_valid = 1'b0; break; end
    end
    i_valid = 1'b0;
    total++;
    if (lat !== 4 || o_result !== 8'h30) begin
      bad++; $display("FAIL busy_latch lat=%0d result=%h want=4 30", lat, o_result);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_done) ndone++;
    end
    total++;
    if (ndone !== 0 || o_result !== 8'h30) begin
      bad++; $display("FAIL busy_extra dones=%0d result=%h want=0 30", ndone, o_result);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_illegal();
    test_back_to_back();
    test_mul();
    test_nomul();
    test_reset_mid();
    test_busy_ignore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
